// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front end: synchronizes and debounces the start/clear
// pushbuttons, turns each debounced press into a single-cycle event, and runs
// the IDLE/RUN/PAUSE state machine that drives the downstream counter stage.
module stopwatch_ctrl #(
  parameter int CLK_FREQ    = 100000000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic       init_regs,
  output logic       count_enabled,
  output logic [1:0] state
);

  localparam int DEBOUNCE_RAW    = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int DEBOUNCE_CYCLES = (DEBOUNCE_RAW < 2) ? 2 : DEBOUNCE_RAW;
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit positions of the two buttons in every per-button vector below.
  localparam int BTN_START = 0;
  localparam int BTN_CLEAR = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       stable_q, stable_d;
  logic [1:0]       prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       press;
  state_t           state_q, state_d;

  // Synchronizer pipeline inputs and previous-stable history for edge detection.
  always_comb begin
    sync1_d = {btn_clear, btn_start};
    sync2_d = sync1_q;
    prev_d  = stable_q;
  end

  // Per-button debouncer: count consecutive cycles the synchronized input
  // disagrees with the stable flag; flip the flag after a full stable window.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    stable_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A press is the first cycle the stable flag is high; releases are ignored.
  assign press = stable_q & ~prev_q;

  // Button-path registers; the debounce counters are cleared too so a reset
  // discards any partially qualified press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        // NOTE: this small counter array is reset explicitly; larger storage arrays normally would not be.
        cnt_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Next-state logic; clear wins whenever both events arrive together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (press[BTN_START] && !press[BTN_CLEAR]) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (press[BTN_CLEAR])      state_d = ST_IDLE;
        else if (press[BTN_START]) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (press[BTN_CLEAR])      state_d = ST_IDLE;
        else if (press[BTN_START]) state_d = ST_RUN;
      end
      ST_BAD: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore outputs decoded from the state register only; the unused code
  // behaves like IDLE until it is flushed on the next edge.
  always_comb begin
    init_regs     = 1'b1;
    count_enabled = 1'b0;
    case (state_q)
      ST_RUN: begin
        init_regs     = 1'b0;
        count_enabled = 1'b1;
      end
      ST_PAUSE: begin
        init_regs     = 1'b0;
        count_enabled = 1'b0;
      end
      default: begin
        init_regs     = 1'b1;
        count_enabled = 1'b0;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 4-cycle debounce window.
// Inputs change on the falling clock edge; outputs are sampled there too.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic       init_regs;
  logic       count_enabled;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  stopwatch_ctrl #(
    .CLK_FREQ   (1000),
    .DEBOUNCE_MS(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_start    (btn_start),
    .btn_clear    (btn_clear),
    .init_regs    (init_regs),
    .count_enabled(count_enabled),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Expected {state, init_regs, count_enabled} for a given state.
  function automatic logic [3:0] expv(input logic [1:0] s);
    case (s)
      S_RUN:   return {s, 2'b01};
      S_PAUSE: return {s, 2'b00};
      default: return {s, 2'b10};
    endcase
  endfunction

  function automatic logic [3:0] obs();
    return {state, init_regs, count_enabled};
  endfunction

  // Advance n rising edges, landing on the following falling edge.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the given buttons long enough to qualify, then release and let the
  // release settle.
  task automatic press(input logic s, input logic c);
    btn_start = s;
    btn_clear = c;
    cycles(8);
    btn_start = 1'b0;
    btn_clear = 1'b0;
    cycles(10);
  endtask

  task automatic test_reset;
    logic [3:0] o, x;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    o = obs(); x = expv(S_IDLE); total++;
    if (o !== x) begin
      bad++;
      $display("FAIL reset_async: got %b want %b", o, x);
    end
    cycles(2);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      o = obs(); total++;
      if (o !== x) begin
        bad++;
        $display("FAIL idle_hold[%0d]: got %b want %b", i, o, x);
      end
    end
  endtask

  task automatic test_glitch;
    logic [3:0] o, x;
    x = expv(S_IDLE);
    for (int w = 1; w <= 3; w++) begin
      btn_start = 1'b1;
      for (int k = 0; k < w; k++) begin
        cycles(1);
        o = obs(); total++;
        if (o !== x) begin
          bad++;
          $display("FAIL glitch_high w=%0d k=%0d: got %b want %b", w, k, o, x);
        end
      end
      btn_start = 1'b0;
      for (int k = 0; k < 5; k++) begin
        cycles(1);
        o = obs(); total++;
        if (o !== x) begin
          bad++;
          $display("FAIL glitch_low w=%0d k=%0d: got %b want %b", w, k, o, x);
        end
      end
    end
  endtask

  task automatic test_start_latency;
    logic [3:0] o, x;
    btn_start = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cycles(1);
      o = obs(); x = expv((e < 7) ? S_IDLE : S_RUN); total++;
      if (o !== x) begin
        bad++;
        $display("FAIL start_latency edge=%0d: got %b want %b", e, o, x);
      end
    end
    btn_start = 1'b0;
    x = expv(S_RUN);
    for (int e = 0; e < 10; e++) begin
      cycles(1);
      o = obs(); total++;
      if (o !== x) begin
        bad++;
        $display("FAIL start_release edge=%0d: got %b want %b", e, o, x);
      end
    end
  endtask

  task automatic test_pause_resume;
    logic [3:0] o, x;
    logic [1:0] steps_s [6];
    logic       steps_b [6];
    // Start, start, start, clear (from PAUSE), start, clear (from RUN).
    steps_b = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    steps_s = '{S_PAUSE, S_RUN, S_PAUSE, S_IDLE, S_RUN, S_IDLE};
    for (int i = 0; i < 6; i++) begin
      press(~steps_b[i], steps_b[i]);
      o = obs(); x = expv(steps_s[i]); total++;
      if (o !== x) begin
        bad++;
        $display("FAIL pause_resume step=%0d: got %b want %b", i, o, x);
      end
    end
  endtask

  task automatic test_clear_idle;
    logic [3:0] o, x;
    press(1'b0, 1'b1);
    o = obs(); x = expv(S_IDLE); total++;
    if (o !== x) begin
      bad++;
      $display("FAIL clear_idle: got %b want %b", o, x);
    end
  endtask

  task automatic test_simultaneous;
    logic [3:0] o, x;
    press(1'b1, 1'b0);
    o = obs(); x = expv(S_RUN); total++;
    if (o !== x) begin
      bad++;
      $display("FAIL simul_setup: got %b want %b", o, x);
    end
    btn_start = 1'b1;
    btn_clear = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cycles(1);
      o = obs(); x = expv((e < 7) ? S_RUN : S_IDLE); total++;
      if (o !== x) begin
        bad++;
        $display("FAIL simul edge=%0d: got %b want %b", e, o, x);
      end
    end
    btn_start = 1'b0;
    btn_clear = 1'b0;
    cycles(10);
    o = obs(); x = expv(S_IDLE); total++;
    if (o !== x) begin
      bad++;
      $display("FAIL simul_release: got %b want %b", o, x);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [3:0] o, x;
    press(1'b1, 1'b0);
    o = obs(); x = expv(S_RUN); total++;
    if (o !== x) begin
      bad++;
      $display("FAIL rst_run_setup: got %b want %b", o, x);
    end
    btn_start = 1'b1;
    cycles(3);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    o = obs(); x = expv(S_IDLE); total++;
    if (o !== x) begin
      bad++;
      $display("FAIL rst_mid_run_async: got %b want %b", o, x);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      cycles(1);
      o = obs(); x = expv((e < 7) ? S_IDLE : S_RUN); total++;
      if (o !== x) begin
        bad++;
        $display("FAIL rst_repress edge=%0d: got %b want %b", e, o, x);
      end
    end
    btn_start = 1'b0;
    cycles(10);
    o = obs(); x = expv(S_RUN); total++;
    if (o !== x) begin
      bad++;
      $display("FAIL rst_repress_release: got %b want %b", o, x);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_start_latency();
    test_pause_resume();
    test_clear_idle();
    test_simultaneous();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, meaning input clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, default 10, meaning required button stable time in ms; DEBOUNCE_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS, minimum 2.
REQ-003 clk  input  1  meaning system clock, all logic on rising edge.
REQ-004 reset_n  input  1  meaning asynchronous active-low reset.
REQ-005 btn_start  input  1  meaning raw, asynchronous start/stop pushbutton, active-high.
REQ-006 btn_clear  input  1  meaning raw, asynchronous clear pushbutton, active-high.
REQ-007 init_regs  output  1  meaning zero request to the downstream Counter stage.
REQ-008 count_enabled  output  1  meaning advance enable to the downstream Counter stage.
REQ-009 state  output  2  meaning current FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 unused.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each button SHALL have an independent debouncer: stable flag plus counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-012 Debouncer SHALL increment its counter each cycle that the synchronized input differs from the stable flag, and SHALL clear the counter in any cycle they match.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 and the input still differs, the stable flag SHALL toggle and the counter SHALL clear on that edge; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change the stable flag.
REQ-014 A press event SHALL be the single-cycle condition stable=1 and previous-cycle stable=0; release SHALL produce no event; holding a button SHALL produce exactly one event.
REQ-015 FSM SHALL have states IDLE, RUN, PAUSE, encoded per REQ-009.
REQ-016 IDLE: start press -> RUN; clear press -> remain IDLE.
REQ-017 RUN: start press -> PAUSE; clear press -> IDLE.
REQ-018 PAUSE: start press -> RUN; clear press -> IDLE.
REQ-019 Simultaneous start and clear press events in the same cycle SHALL take the clear transition.
REQ-020 State register SHALL update on the clock edge ending the press-event cycle.
REQ-021 Outputs SHALL be Moore, decoded from the state register only: IDLE init_regs=1 count_enabled=0; RUN init_regs=0 count_enabled=1; PAUSE init_regs=0 count_enabled=0.
REQ-022 Unused encoding 11 SHALL transition to IDLE on the next edge and drive init_regs=1, count_enabled=0 meanwhile.
REQ-023 No combinational path SHALL exist from btn_start or btn_clear to any output.
REQ-024 Latency, raw button rising to state change: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge, with button held steady.

Reset
REQ-025 reset_n=0 SHALL immediately, without a clock, force state IDLE, init_regs=1, count_enabled=0, all synchronizer flops, stable flags, previous-stable flags and debounce counters to 0.
REQ-026 Reset asserted mid-RUN or mid-debounce SHALL discard any partial debounce; a button held through reset release SHALL generate one press event after full debounce.
REQ-027 Reset deassertion SHALL be taken synchronously to clk by the instantiating top; no internal reset synchronizer.

Verification
(use CLK_FREQ=1000, DEBOUNCE_MS=4, giving DEBOUNCE_CYCLES=4)
REQ-028 Reset then idle 20 cycles -> state=00, init_regs=1, count_enabled=0 throughout.
REQ-029 btn_start high 10 cycles from IDLE -> state=01, count_enabled=1, init_regs=0 exactly 7 edges after btn_start rises; single transition only.
REQ-030 btn_start pulses of 1, 2, 3 cycles separated by 5 low cycles -> no state change.
REQ-031 RUN, start press -> PAUSE (10, both outputs 0); start press -> RUN; clear press -> IDLE (init_regs=1).
REQ-032 RUN, btn_start and btn_clear rise on the same cycle, held 10 cycles -> state=00, never 10.
REQ-033 RUN, reset_n pulsed low mid-cycle while btn_start held -> outputs IDLE values asynchronously; after release, one press event -> RUN 7 edges later.
